// File: rtl/mpu_memory_ctrl.sv
// Byte-addressed MPU memory: unaligned little-endian fetch window,
// byte-enabled write port, post-reset clear engine.
module mpu_memory_ctrl #(
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 128,
  parameter int RD_BYTES = 6,
  parameter int WR_BYTES = 4,
  parameter bit WRAP     = 1'b1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  output logic                  init_busy,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [8*RD_BYTES-1:0] rd_data,
  output logic                  rd_data_valid,
  output logic                  rd_err,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [8*WR_BYTES-1:0] wr_data,
  input  logic [WR_BYTES-1:0]   wr_be,
  output logic                  wr_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = ADDR_W + 3;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t                      state;
  state_t                      state_nxt;
  logic [AW-1:0]               clr_ptr;
  logic                        clr_last;
  logic [7:0]                  mem [DEPTH];
  logic                        rd_fire;
  logic                        wr_fire;
  logic [EW-1:0]               rd_ea;
  logic [EW-1:0]               wr_ea;
  logic [8*RD_BYTES-1:0]       rd_win;
  logic                        rd_oob;
  logic [WR_BYTES-1:0]         wr_ok;
  logic [WR_BYTES-1:0][AW-1:0] wr_idx;
  logic                        wr_drop;
  logic                        rd_pend;
  logic [8*RD_BYTES-1:0]       rd_buf;
  logic                        rd_buf_err;
  logic                        wr_drop_q;

  assign clr_last = (clr_ptr == AW'(DEPTH - WR_BYTES));
  assign rd_fire  = rd_valid & rd_ready & sys_rst_n;
  assign wr_fire  = wr_valid & wr_ready & sys_rst_n;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state <= CLEAR;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      CLEAR: if (clr_last) state_nxt = IDLE;
      IDLE:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    init_busy = 1'b1;
    rd_ready  = 1'b0;
    wr_ready  = 1'b0;
    if (state == IDLE) begin
      init_busy = 1'b0;
      rd_ready  = 1'b1;
      wr_ready  = 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n)          clr_ptr <= '0;
    else if (state == CLEAR) clr_ptr <= clr_ptr + AW'(WR_BYTES);
  end

  // Byte addresses are formed wide so WRAP=0 can see overflow past DEPTH
  always_comb begin
    rd_win = '0;
    rd_oob = 1'b0;
    rd_ea  = '0;
    for (int k = 0; k < RD_BYTES; k++) begin
      rd_ea = EW'(rd_addr) + EW'(k);
      if (WRAP || rd_ea < EW'(DEPTH)) rd_win[8*k +: 8] = mem[rd_ea[AW-1:0]];
      else                            rd_oob = 1'b1;
    end
  end

  always_comb begin
    wr_ok  = '0;
    wr_idx = '0;
    wr_ea  = '0;
    for (int k = 0; k < WR_BYTES; k++) begin
      wr_ea     = EW'(wr_addr) + EW'(k);
      wr_ok[k]  = WRAP || wr_ea < EW'(DEPTH);
      wr_idx[k] = wr_ea[AW-1:0];
    end
  end

  assign wr_drop = |(wr_be & ~wr_ok);

  always_ff @(posedge sys_clk) begin
    if (sys_rst_n && state == CLEAR) begin
      for (int k = 0; k < WR_BYTES; k++)
        mem[clr_ptr + AW'(k)] <= '0;
    end else if (wr_fire) begin
      for (int k = 0; k < WR_BYTES; k++)
        if (wr_be[k] && wr_ok[k]) mem[wr_idx[k]] <= wr_data[8*k +: 8];
    end
  end

  // Window is snapshotted at accept so a same-cycle write is not seen
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      rd_pend       <= 1'b0;
      rd_buf        <= '0;
      rd_buf_err    <= 1'b0;
      wr_drop_q     <= 1'b0;
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
      rd_err        <= 1'b0;
      wr_err        <= 1'b0;
    end else begin
      rd_pend       <= rd_fire;
      wr_drop_q     <= wr_fire & wr_drop;
      rd_data_valid <= rd_pend;
      wr_err        <= wr_drop_q;
      if (rd_fire) begin
        rd_buf     <= rd_win;
        rd_buf_err <= rd_oob;
      end
      if (rd_pend) begin
        rd_data <= rd_buf;
        rd_err  <= rd_buf_err;
      end
    end
  end

endmodule

// File: tb/tb_mpu_memory_ctrl.sv
// Bench for mpu_memory_ctrl: WRAP=1 and WRAP=0 instances on shared
// stimulus, checked against a byte-array reference model.
module tb_mpu_memory_ctrl;
  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        rd_valid = 1'b0;
  logic [15:0] rd_addr = '0;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;

  logic        busy1, rr1, wr1, rdv1, rerr1, werr1;
  logic        busy0, rr0, wr0, rdv0, rerr0, werr0;
  logic [47:0] rdat1, rdat0;

  int checks = 0;
  int failures = 0;

  bit [7:0] m1 [128];
  bit [7:0] m0 [128];

  bit          s_v, s_e1, s_e0, s_we1, s_we0;
  logic [47:0] s_d1, s_d0;
  logic [47:0] last_d1, last_d0;
  bit          last_e1, last_e0;

  always #5 sys_clk = ~sys_clk;

  mpu_memory_ctrl #(.WRAP(1'b1)) dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_busy(busy1),
    .rd_valid(rd_valid), .rd_ready(rr1), .rd_addr(rd_addr),
    .rd_data(rdat1), .rd_data_valid(rdv1), .rd_err(rerr1),
    .wr_valid(wr_valid), .wr_ready(wr1), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .wr_err(werr1)
  );

  mpu_memory_ctrl #(.WRAP(1'b0)) dut0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_busy(busy0),
    .rd_valid(rd_valid), .rd_ready(rr0), .rd_addr(rd_addr),
    .rd_data(rdat0), .rd_data_valid(rdv0), .rd_err(rerr0),
    .wr_valid(wr_valid), .wr_ready(wr0), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .wr_err(werr0)
  );

  function automatic logic [47:0] model_rd(input bit wrap, input int addr,
                                           output bit err);
    logic [47:0] r;
    int a;
    r = '0;
    err = 1'b0;
    for (int k = 0; k < 6; k++) begin
      a = addr + k;
      if (wrap)         r[8*k +: 8] = m1[a % 128];
      else if (a >= 128) err = 1'b1;
      else              r[8*k +: 8] = m0[a];
    end
    return r;
  endfunction

  function automatic bit model_wr(input bit wrap, input int addr,
                                  input logic [31:0] d, input logic [3:0] be);
    bit drop;
    int a;
    drop = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a = addr + k;
      if (be[k]) begin
        if (wrap)          m1[a % 128] = d[8*k +: 8];
        else if (a >= 128) drop = 1'b1;
        else               m0[a] = d[8*k +: 8];
      end
    end
    return drop;
  endfunction

  // One IDLE-state cycle; outputs after the edge reflect the previous accept
  task automatic step(input bit rv, input int ra, input bit wv, input int wa,
                      input logic [31:0] wd, input logic [3:0] wbe);
    bit ev, ewe1, ewe0;
    rd_valid = rv;
    rd_addr  = ra[15:0];
    wr_valid = wv;
    wr_addr  = wa[15:0];
    wr_data  = wd;
    wr_be    = wbe;
    @(posedge sys_clk);
    ev   = s_v;
    ewe1 = s_we1;
    ewe0 = s_we0;
    if (ev) begin
      last_d1 = s_d1; last_e1 = s_e1;
      last_d0 = s_d0; last_e0 = s_e0;
    end
    s_v = rv;
    if (rv) begin
      s_d1 = model_rd(1'b1, ra & 16'hFFFF, s_e1);
      s_d0 = model_rd(1'b0, ra & 16'hFFFF, s_e0);
    end
    s_we1 = wv ? model_wr(1'b1, wa & 16'hFFFF, wd, wbe) : 1'b0;
    s_we0 = wv ? model_wr(1'b0, wa & 16'hFFFF, wd, wbe) : 1'b0;
    @(negedge sys_clk);
    rd_valid = 1'b0;
    wr_valid = 1'b0;
    checks++;
    if (rr1 !== 1'b1 || wr1 !== 1'b1 || rr0 !== 1'b1 || wr0 !== 1'b1) begin
      failures++;
      $display("FAIL ready: got %b%b%b%b want 1111", rr1, wr1, rr0, wr0);
    end
    checks++;
    if (rdv1 !== ev || rdv0 !== ev) begin
      failures++;
      $display("FAIL rd_data_valid: got %b/%b want %b", rdv1, rdv0, ev);
    end
    checks++;
    if (rdat1 !== last_d1 || rerr1 !== last_e1) begin
      failures++;
      $display("FAIL rd_data_wrap1: got %h err %b want %h err %b",
               rdat1, rerr1, last_d1, last_e1);
    end
    checks++;
    if (rdat0 !== last_d0 || rerr0 !== last_e0) begin
      failures++;
      $display("FAIL rd_data_wrap0: got %h err %b want %h err %b",
               rdat0, rerr0, last_d0, last_e0);
    end
    checks++;
    if (werr1 !== ewe1 || werr0 !== ewe0) begin
      failures++;
      $display("FAIL wr_err: got %b/%b want %b/%b", werr1, werr0, ewe1, ewe0);
    end
  endtask

  task automatic test_reset();
    int cnt;
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    rd_valid  = 1'b0;
    wr_valid  = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (busy1 !== 1'b1 || busy0 !== 1'b1 || rr1 !== 1'b0 || wr1 !== 1'b0 ||
        rr0 !== 1'b0 || wr0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: busy %b%b ready %b%b%b%b want 11 0000",
               busy1, busy0, rr1, wr1, rr0, wr0);
    end
    checks++;
    if (rdv1 !== 1'b0 || rdv0 !== 1'b0 || rdat1 !== 48'h0 || rdat0 !== 48'h0 ||
        rerr1 !== 1'b0 || rerr0 !== 1'b0 || werr1 !== 1'b0 || werr0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: rdv %b%b data %h/%h err %b%b werr %b%b want 0",
               rdv1, rdv0, rdat1, rdat0, rerr1, rerr0, werr1, werr0);
    end
    for (int i = 0; i < 128; i++) begin
      m1[i] = 8'h00;
      m0[i] = 8'h00;
    end
    s_v = 0; s_we1 = 0; s_we0 = 0;
    last_d1 = '0; last_d0 = '0; last_e1 = 0; last_e0 = 0;
    // requests held during clear must have no effect
    rd_valid  = 1'b1;
    rd_addr   = 16'h0010;
    wr_valid  = 1'b1;
    wr_addr   = 16'h0010;
    wr_data   = 32'hFFFFFFFF;
    wr_be     = 4'hF;
    sys_rst_n = 1'b1;
    cnt = 0;
    while ((busy1 || busy0) && cnt < 100) begin
      checks++;
      if (busy1 !== busy0 || rr1 !== 1'b0 || wr1 !== 1'b0 || rr0 !== 1'b0 ||
          wr0 !== 1'b0 || rdv1 !== 1'b0 || rdv0 !== 1'b0 ||
          werr1 !== 1'b0 || werr0 !== 1'b0) begin
        failures++;
        $display("FAIL clear_phase: cycle %0d busy %b%b ready %b%b%b%b rdv %b%b werr %b%b",
                 cnt, busy1, busy0, rr1, wr1, rr0, wr0, rdv1, rdv0, werr1, werr0);
      end
      cnt++;
      @(posedge sys_clk);
      @(negedge sys_clk);
    end
    rd_valid = 1'b0;
    wr_valid = 1'b0;
    checks++;
    if (cnt != 32) begin
      failures++;
      $display("FAIL clear_length: got %0d cycles want 32", cnt);
    end
  endtask

  task automatic test_read_zero();
    step(1, 16'h00, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (rdv1 !== 1'b1 || rdat1 !== 48'h0 || rerr1 !== 1'b0) begin
      failures++;
      $display("FAIL read_zero: got v%b %h err %b want v1 0 err 0", rdv1, rdat1, rerr1);
    end
  endtask

  task automatic test_write_read();
    step(0, 0, 1, 16'h10, 32'hDDCCBBAA, 4'hF);
    step(1, 16'h10, 0, 0, 0, 0);
    checks++;
    if (rdv1 !== 1'b0) begin
      failures++;
      $display("FAIL read_latency: got valid %b at accept edge want 0", rdv1);
    end
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (rdv1 !== 1'b1 || rdat1 !== 48'h0000DDCCBBAA) begin
      failures++;
      $display("FAIL write_read: got v%b %h want v1 0000ddccbbaa", rdv1, rdat1);
    end
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (rdv1 !== 1'b0 || rdat1 !== 48'h0000DDCCBBAA) begin
      failures++;
      $display("FAIL valid_pulse_hold: got v%b %h want v0 0000ddccbbaa", rdv1, rdat1);
    end
  endtask

  task automatic test_byte_enable();
    step(0, 0, 1, 16'h10, 32'h11223344, 4'b0101);
    step(1, 16'h10, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (rdat1 !== 48'h0000DD22BB44 || rdat0 !== 48'h0000DD22BB44) begin
      failures++;
      $display("FAIL byte_enable: got %h/%h want 0000dd22bb44", rdat1, rdat0);
    end
  endtask

  task automatic test_wrap();
    step(0, 0, 1, 16'h7E, 32'h04030201, 4'hF);
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (werr1 !== 1'b0 || werr0 !== 1'b1) begin
      failures++;
      $display("FAIL wr_err_edge: got %b/%b want 0/1", werr1, werr0);
    end
    step(1, 16'h7E, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (rdat1 !== 48'h000004030201 || rerr1 !== 1'b0) begin
      failures++;
      $display("FAIL wrap_read: got %h err %b want 000004030201 err 0", rdat1, rerr1);
    end
    checks++;
    if (rdat0 !== 48'h000000000201 || rerr0 !== 1'b1) begin
      failures++;
      $display("FAIL range_read: got %h err %b want 000000000201 err 1", rdat0, rerr0);
    end
  endtask

  task automatic test_same_cycle();
    step(1, 16'h10, 1, 16'h10, 32'h55555555, 4'hF);
    step(1, 16'h10, 0, 0, 0, 0);
    checks++;
    if (rdat1 !== 48'h0000DD22BB44) begin
      failures++;
      $display("FAIL same_cycle_old: got %h want 0000dd22bb44", rdat1);
    end
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (rdat1 !== 48'h000055555555) begin
      failures++;
      $display("FAIL next_read_new: got %h want 000055555555", rdat1);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++)
      step(1, 16'h0C + i, 1, 16'h40 + 4 * i, $urandom, 4'hF);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    int ra, wa;
    for (int i = 0; i < 400; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535))
                                       : int'($urandom_range(0, 140));
      wa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535))
                                       : int'($urandom_range(0, 140));
      step($urandom_range(0, 1), ra, $urandom_range(0, 1), wa,
           $urandom, 4'($urandom_range(0, 15)));
    end
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    step(0, 0, 1, 16'h10, 32'h99887766, 4'hF);
    step(1, 16'h10, 0, 0, 0, 0);
    test_reset();
    step(1, 16'h10, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (rdv1 !== 1'b1 || rdat1 !== 48'h0 || rdat0 !== 48'h0) begin
      failures++;
      $display("FAIL reset_mid_read: got v%b %h/%h want v1 0", rdv1, rdat1, rdat0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge sys_clk);
    test_reset();
    test_read_zero();
    test_write_read();
    test_byte_enable();
    test_wrap();
    test_same_cycle();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
